// File: rtl/next186_pkg.sv
// Shared definitions for the Next186 BIOS loader.
//   state_t        : loader FSM states
//   DEF_BIOS_BASE  : default SRAM byte address of BIOS byte 0
//   DEF_BIOS_SIZE  : default BIOS image length in bytes
//   sat_inc        : saturating increment for the byte counter
package next186_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam int unsigned MEM_AW = 21;
  localparam int unsigned CKS_W  = 16;
  localparam int unsigned CNT_W  = 17;

  localparam logic [MEM_AW-1:0] DEF_BIOS_BASE = 21'h1F0000;
  localparam int unsigned       DEF_BIOS_SIZE = 65536;

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/bios_loader.sv
// bios_loader: copies a BIOS image streamed from the HPS (ioctl_*) into SRAM
// one byte at a time, stalling the stream while each write is outstanding.
// Ports:
//   clk_sys, reset                 : clock, async active-high reset
//   ioctl_download/wr/addr/dout/index : HPS download stream (inputs)
//   ioctl_wait                     : stall to HPS
//   mem_req/mem_addr/mem_dout      : SRAM write request, held until mem_ack
//   mem_ack                        : single-cycle write completion
//   bios_loaded/load_error         : final load status
//   core_hold                      : keeps the CPU core in reset while loading
//   checksum                       : 16-bit wrapping sum of written bytes
module bios_loader
  import next186_pkg::*;
#(
  parameter logic [15:0]       BIOS_INDEX = 16'd0,
  parameter logic [MEM_AW-1:0] BIOS_BASE  = DEF_BIOS_BASE,
  parameter int unsigned       BIOS_SIZE  = DEF_BIOS_SIZE
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [15:0]       ioctl_index,
  output logic              ioctl_wait,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_dout,
  input  logic              mem_ack,
  output logic              bios_loaded,
  output logic              load_error,
  output logic              core_hold,
  output logic [CKS_W-1:0]  checksum
);

  state_t              r_state;
  logic [MEM_AW-1:0]   r_addr;
  logic [7:0]          r_dout;
  logic                r_req;
  logic                r_wait;
  logic [CKS_W-1:0]    r_cks;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;
  logic                r_loaded;
  logic                r_load_error;
  logic                r_hold;

  state_t              w_state_nxt;
  logic [MEM_AW-1:0]   w_addr_nxt;
  logic [7:0]          w_dout_nxt;
  logic                w_req_nxt;
  logic                w_wait_nxt;
  logic [CKS_W-1:0]    w_cks_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_err_nxt;
  logic                w_loaded_nxt;
  logic                w_load_error_nxt;
  logic                w_hold_nxt;

  logic                w_is_bios;
  logic                w_in_range;
  logic                w_complete;

  assign w_is_bios  = (ioctl_index == BIOS_INDEX);
  assign w_in_range = (32'(ioctl_addr) < BIOS_SIZE);
  // Image is good only if exactly BIOS_SIZE bytes landed and nothing was dropped.
  assign w_complete = (32'(r_cnt) == BIOS_SIZE) && !r_err;

  // State and registered outputs.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_dout       <= '0;
      r_req        <= 1'b0;
      r_wait       <= 1'b0;
      r_cks        <= '0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_loaded     <= 1'b0;
      r_load_error <= 1'b0;
      r_hold       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_dout       <= w_dout_nxt;
      r_req        <= w_req_nxt;
      r_wait       <= w_wait_nxt;
      r_cks        <= w_cks_nxt;
      r_cnt        <= w_cnt_nxt;
      r_err        <= w_err_nxt;
      r_loaded     <= w_loaded_nxt;
      r_load_error <= w_load_error_nxt;
      r_hold       <= w_hold_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_dout_nxt  = r_dout;
    w_req_nxt   = r_req;
    w_wait_nxt  = r_wait;
    w_cks_nxt   = r_cks;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;

    unique case (r_state)
      IDLE, DONE, ERROR: begin
        if (ioctl_download && w_is_bios) begin
          w_state_nxt = LOAD;
          w_cks_nxt   = '0;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b0;
        end
      end
      LOAD: begin
        if (!ioctl_download) begin
          w_state_nxt = w_complete ? DONE : ERROR;
        end else if (ioctl_wr && w_is_bios) begin
          if (w_in_range) begin
            w_addr_nxt  = BIOS_BASE + ioctl_addr[MEM_AW-1:0];
            w_dout_nxt  = ioctl_dout;
            w_req_nxt   = 1'b1;
            w_wait_nxt  = 1'b1;
            w_state_nxt = WRITE;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      WRITE: begin
        // A strobe here ignored ioctl_wait; the byte is lost.
        if (ioctl_wr) begin
          w_err_nxt = 1'b1;
        end
        // A download that ended meanwhile is resolved back in LOAD.
        if (mem_ack) begin
          w_req_nxt   = 1'b0;
          w_wait_nxt  = 1'b0;
          w_cks_nxt   = r_cks + CKS_W'(r_dout);
          w_cnt_nxt   = sat_inc(r_cnt);
          w_state_nxt = LOAD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
        w_wait_nxt  = 1'b0;
      end
    endcase

    // Status flags follow the state being entered so hold drops with loaded rising.
    w_loaded_nxt     = (w_state_nxt == DONE);
    w_load_error_nxt = (w_state_nxt == ERROR);
    w_hold_nxt       = (w_state_nxt == LOAD) || (w_state_nxt == WRITE);
  end

  assign ioctl_wait  = r_wait;
  assign mem_req     = r_req;
  assign mem_addr    = r_addr;
  assign mem_dout    = r_dout;
  assign bios_loaded = r_loaded;
  assign load_error  = r_load_error;
  assign core_hold   = r_hold;
  assign checksum    = r_cks;

endmodule
